// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_stall_ctrl_pkg
//  Brief   : Shared types and helpers for the pipeline hazard/stall controller.
//  Revision: 1.0
// ============================================================================
package hazard_stall_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

  localparam int c_REG_ZERO = 0;

  // Width of the mul/div occupancy down-counter; never narrower than one bit.
  function automatic int md_cnt_width(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage : hazard_stall_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_stall_ctrl_if
//  Brief   : Hazard inputs from the pipeline and stall/flush controls back to it.
//  Revision: 1.0
// ============================================================================
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              ex_md_start;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_flush;
  logic              exmem_flush;
  logic              md_busy;
  logic              md_done;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  // Pipeline side
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read,
           ex_branch_taken, ex_md_start,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
           md_busy, md_done, stall_cycles, flush_events
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read,
           ex_branch_taken, ex_md_start,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush,
           md_busy, md_done, stall_cycles, flush_events
  );

endinterface : hazard_stall_ctrl_if
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : sat_counter
//  Brief   : Up-counter that sticks at all-ones instead of wrapping.
//  Revision: 1.0
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_stall_ctrl
//  Brief   : Load-use / branch-flush / mul-div stall controller for the pipeline.
//  Revision: 1.0
// ============================================================================
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input wire logic           clk,
  input wire logic           rst,
  hazard_stall_ctrl_if.slave hz
);

  localparam int                 c_MD_CW     = md_cnt_width(MD_LAT);
  localparam logic [c_MD_CW-1:0] c_MD_RELOAD = c_MD_CW'(MD_LAT - 2);

  hz_state_t          r_state;
  logic [c_MD_CW-1:0] r_md_cnt;

  logic w_load_use;
  logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
  logic w_exmem_flush, w_md_busy, w_md_done;
  logic w_flush_inc;
  logic [CNT_W-1:0] w_stall_q, w_flush_q;

  // r0 is hard-wired, so a load targeting it can never create a dependency.
  assign w_load_use = hz.ex_mem_read && (hz.ex_rd != REG_AW'(c_REG_ZERO)) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));

  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_en     = 1'b1;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_md_busy     = 1'b0;
    w_md_done     = 1'b0;
    w_flush_inc   = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (hz.ex_branch_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_flush_inc  = 1'b1;
          end else if (hz.ex_md_start) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_flush = 1'b1;
            w_md_busy     = 1'b1;
          end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (r_md_cnt != '0) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_flush = 1'b1;
            w_md_busy     = 1'b1;
          end else begin
            w_md_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (!hz.ex_branch_taken && hz.ex_md_start) begin
            r_state  <= MD_BUSY;
            r_md_cnt <= c_MD_RELOAD;
          end
        end
        MD_BUSY: begin
          if (r_md_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_md_cnt <= r_md_cnt - c_MD_CW'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~w_pc_en),
    .q   (w_stall_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_inc),
    .q   (w_flush_q)
  );

  assign hz.pc_en        = w_pc_en;
  assign hz.ifid_en      = w_ifid_en;
  assign hz.ifid_flush   = w_ifid_flush;
  assign hz.idex_en      = w_idex_en;
  assign hz.idex_flush   = w_idex_flush;
  assign hz.exmem_flush  = w_exmem_flush;
  assign hz.md_busy      = w_md_busy;
  assign hz.md_done      = w_md_done;
  assign hz.stall_cycles = w_stall_q;
  assign hz.flush_events = w_flush_q;

endmodule : hazard_stall_ctrl
`default_nettype wire
